// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : updown_mod_counter
// Purpose  : Synchronous up/down counter with a programmable modulus
//            (0..MAX), parallel load with clamp, count enable and a
//            selectable wrap or saturate behaviour at both count limits.
//            A registered terminal-count flag supports cascading.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH     : counter width in bits (>= 1)
//   MAX       : upper count limit, modulus - 1 (0 < MAX <= 2**WIDTH-1)
//   RESET_VAL : value forced into q by reset (<= MAX)
//   SATURATE  : 0 = wrap at the limits, 1 = hold at the limits
// Ports
//   clk  in  1     : clock, all state changes on the rising edge
//   rst  in  1     : synchronous active-high reset
//   en   in  1     : count enable
//   up   in  1     : direction, 1 = up, 0 = down (used only when counting)
//   load in  1     : synchronous parallel load (beats en)
//   d    in  WIDTH : load data, clamped to MAX
//   q    out WIDTH : registered count
//   tc   out 1     : registered terminal-count / limit-event flag
// ============================================================================
module updown_mod_counter #(
  parameter int WIDTH     = 4,
  parameter int MAX       = (1 << WIDTH) - 1,
  parameter int RESET_VAL = 0,
  parameter int SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc
);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  localparam longint c_full_scale = (64'sd1 <<< WIDTH) - 64'sd1;

  if (WIDTH < 1) begin : g_bad_width
    $error("updown_mod_counter: WIDTH must be >= 1");
  end

  if ((MAX <= 0) || (longint'(MAX) > c_full_scale)) begin : g_bad_max
    $error("updown_mod_counter: MAX must satisfy 0 < MAX <= 2**WIDTH-1");
  end

  if ((RESET_VAL < 0) || (RESET_VAL > MAX)) begin : g_bad_reset_val
    $error("updown_mod_counter: RESET_VAL must satisfy 0 <= RESET_VAL <= MAX");
  end

  if ((SATURATE != 0) && (SATURATE != 1)) begin : g_bad_saturate
    $error("updown_mod_counter: SATURATE must be 0 or 1");
  end

  // --------------------------------------------------------------------------
  // Constants at counter width
  // --------------------------------------------------------------------------
  localparam logic [WIDTH-1:0] c_max       = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] c_reset_val = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] c_zero      = '0;
  localparam logic [WIDTH-1:0] c_one       = WIDTH'(1);
  localparam logic             c_saturate  = (SATURATE != 0);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc_q;
  logic             tc_d;

  // Limit detection and load clamp
  logic             at_max;
  logic             at_zero;
  logic [WIDTH-1:0] d_clamped;

  assign at_max    = (q_q == c_max);
  assign at_zero   = (q_q == c_zero);
  assign d_clamped = (d > c_max) ? c_max : d;

  // --------------------------------------------------------------------------
  // Next-state logic. Reset is handled in the register process, so the
  // priority here is load > en > hold. The limit compare is made on the
  // current value before any arithmetic, so the increment/decrement can
  // never step outside 0..MAX and binary overflow is never exercised.
  // tc defaults low: it only marks a cycle produced by a count at a limit.
  // --------------------------------------------------------------------------
  always_comb begin
    q_d  = q_q;
    tc_d = 1'b0;

    if (load) begin
      q_d = d_clamped;
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          tc_d = 1'b1;
          q_d  = c_saturate ? c_max : c_zero;
        end else begin
          q_d = q_q + c_one;
        end
      end else begin
        if (at_zero) begin
          tc_d = 1'b1;
          q_d  = c_saturate ? c_zero : c_max;
        end else begin
          q_d = q_q - c_one;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registers with synchronous reset; reset discards any pending wrap.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q  <= c_reset_val;
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

  // Outputs come straight from flops
  assign q  = q_q;
  assign tc = tc_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_updown_mod_counter
// Purpose  : Self-checking bench for updown_mod_counter. Four instances:
//            0 = binary 0..15 wrap, reset to 15
//            1 = decade 0..9 wrap (cascade low digit)
//            2 = decade 0..9 saturating
//            3 = decade 0..9 wrap, en driven by instance 1's tc
//            A behavioural model predicts q/tc for every instance on every
//            cycle; directed sections add fixed expected values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_updown_mod_counter;

  localparam int N = 4;
  localparam int MAXV [N] = '{15, 9, 9, 9};
  localparam int RSTV [N] = '{15, 0, 0, 0};
  localparam int SATV [N] = '{0, 0, 1, 0};

  logic       clk = 1'b0;
  logic       rst_v  [N];
  logic       load_v [N];
  logic       en_v   [N];
  logic       up_v   [N];
  logic [3:0] d_v    [N];
  logic [3:0] q_v    [N];
  logic       tc_v   [N];

  int mq  [N];
  int mtc [N];
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MAX(15), .RESET_VAL(15), .SATURATE(0)) u_bin (
    .clk(clk), .rst(rst_v[0]), .en(en_v[0]), .up(up_v[0]), .load(load_v[0]),
    .d(d_v[0]), .q(q_v[0]), .tc(tc_v[0])
  );

  updown_mod_counter #(.WIDTH(4), .MAX(9), .RESET_VAL(0), .SATURATE(0)) u_dec (
    .clk(clk), .rst(rst_v[1]), .en(en_v[1]), .up(up_v[1]), .load(load_v[1]),
    .d(d_v[1]), .q(q_v[1]), .tc(tc_v[1])
  );

  updown_mod_counter #(.WIDTH(4), .MAX(9), .RESET_VAL(0), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst_v[2]), .en(en_v[2]), .up(up_v[2]), .load(load_v[2]),
    .d(d_v[2]), .q(q_v[2]), .tc(tc_v[2])
  );

  updown_mod_counter #(.WIDTH(4), .MAX(9), .RESET_VAL(0), .SATURATE(0)) u_casc (
    .clk(clk), .rst(rst_v[3]), .en(tc_v[1]), .up(up_v[3]), .load(load_v[3]),
    .d(d_v[3]), .q(q_v[3]), .tc(tc_v[3])
  );

  // --------------------------------------------------------------------------
  // Single comparison point
  // --------------------------------------------------------------------------
  task automatic check_val(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: one edge of a modulo-(mx+1) counter, written directly
  // from the operating rules.
  // --------------------------------------------------------------------------
  task automatic model_next(input int cur, input int mx, input int sat, input int rv,
                            input int r, input int ld, input int e, input int u,
                            input int dat, output int nq, output int ntc);
    nq  = cur;
    ntc = 0;
    if (r != 0) begin
      nq = rv;
    end else if (ld != 0) begin
      nq = (dat > mx) ? mx : dat;
    end else if (e != 0) begin
      if (u != 0) begin
        if (cur == mx) begin
          ntc = 1;
          nq  = (sat != 0) ? mx : 0;
        end else begin
          nq = cur + 1;
        end
      end else begin
        if (cur == 0) begin
          ntc = 1;
          nq  = (sat != 0) ? 0 : mx;
        end else begin
          nq = cur - 1;
        end
      end
    end
  endtask

  // Advance one clock: predict, clock, sample 1 time unit after the edge.
  task automatic tick();
    int nq;
    int ntc;
    int en_eff;
    int prev_tc1;
    prev_tc1 = mtc[1];
    for (int i = 0; i < N; i++) begin
      en_eff = (i == 3) ? prev_tc1 : int'(en_v[i]);
      model_next(mq[i], MAXV[i], SATV[i], RSTV[i], int'(rst_v[i]), int'(load_v[i]),
                 en_eff, int'(up_v[i]), int'(d_v[i]), nq, ntc);
      mq[i]  = nq;
      mtc[i] = ntc;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("model_q[%0d]", i), int'(q_v[i]), mq[i]);
      check_val($sformatf("model_tc[%0d]", i), int'(tc_v[i]), mtc[i]);
    end
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      rst_v[i]  = 1'b0;
      load_v[i] = 1'b0;
      en_v[i]   = 1'b0;
      up_v[i]   = 1'b1;
      d_v[i]    = 4'd0;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      mq[i]  = 0;
      mtc[i] = 0;
    end
    idle_all();

    // ---------------- reset ----------------
    for (int i = 0; i < N; i++) rst_v[i] = 1'b1;
    tick();
    check_val("reset_q_bin", int'(q_v[0]), 15);
    check_val("reset_q_dec", int'(q_v[1]), 0);
    check_val("reset_tc_bin", int'(tc_v[0]), 0);
    idle_all();

    // ---------------- binary down wrap and decade up count ----------------
    en_v[0] = 1'b1; up_v[0] = 1'b0;
    en_v[1] = 1'b1; up_v[1] = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      if (k > 12) en_v[1] = 1'b0;
      tick();
      check_val("down_wrap_q", int'(q_v[0]), (15 - k + 32) % 16);
      check_val("down_wrap_tc", int'(tc_v[0]), (k == 16) ? 1 : 0);
      if (k <= 12) begin
        check_val("decade_q", int'(q_v[1]), k % 10);
        check_val("decade_tc", int'(tc_v[1]), (k == 10) ? 1 : 0);
      end
    end
    idle_all();

    // ---------------- saturating counter ----------------
    load_v[2] = 1'b1; d_v[2] = 4'd8;
    tick();
    check_val("sat_load_q", int'(q_v[2]), 8);
    load_v[2] = 1'b0; en_v[2] = 1'b1; up_v[2] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check_val("sat_up_q", int'(q_v[2]), 9);
      check_val("sat_up_tc", int'(tc_v[2]), (k > 1) ? 1 : 0);
    end
    up_v[2] = 1'b0;
    tick();
    check_val("sat_down_q", int'(q_v[2]), 8);
    check_val("sat_down_tc", int'(tc_v[2]), 0);
    idle_all();

    // ---------------- load priority, clamp, reset over load ----------------
    load_v[1] = 1'b1; en_v[1] = 1'b1; d_v[1] = 4'd4;
    tick();
    check_val("load_over_en_q", int'(q_v[1]), 4);
    d_v[1] = 4'd13;
    tick();
    check_val("load_clamp_q", int'(q_v[1]), 9);
    rst_v[1] = 1'b1; d_v[1] = 4'd3;
    rst_v[0] = 1'b1; load_v[0] = 1'b1; d_v[0] = 4'd3;
    tick();
    check_val("rst_over_load_dec", int'(q_v[1]), 0);
    check_val("rst_over_load_bin", int'(q_v[0]), 15);
    idle_all();

    // ---------------- direction flip and hold ----------------
    load_v[1] = 1'b1; d_v[1] = 4'd5;
    tick();
    load_v[1] = 1'b0; en_v[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      up_v[1] = (k % 2 == 0);
      tick();
      check_val("flip_q", int'(q_v[1]), (k % 2 == 0) ? 6 : 5);
    end
    en_v[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("hold_q", int'(q_v[1]), 5);
      check_val("hold_tc", int'(tc_v[1]), 0);
    end
    idle_all();

    // ---------------- cascade of two decades ----------------
    // The high digit is enabled by the low digit's registered tc, so it
    // advances on the edge after the low digit's wrap.
    rst_v[1] = 1'b1; rst_v[3] = 1'b1;
    tick();
    idle_all();
    en_v[1] = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      tick();
      if (k == 99) begin
        check_val("casc99_a", int'(q_v[1]), 9);
        check_val("casc99_b", int'(q_v[3]), 9);
      end
      if (k == 100) begin
        check_val("casc100_a", int'(q_v[1]), 0);
        check_val("casc100_a_tc", int'(tc_v[1]), 1);
      end
      if (k == 101) begin
        check_val("casc101_a", int'(q_v[1]), 1);
        check_val("casc101_b", int'(q_v[3]), 0);
        check_val("casc101_b_tc", int'(tc_v[3]), 1);
      end
    end
    idle_all();

    // ---------------- randomized traffic ----------------
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        rst_v[i]  = ($urandom_range(0, 39) == 0);
        load_v[i] = ($urandom_range(0, 7) == 0);
        en_v[i]   = ($urandom_range(0, 3) != 0);
        up_v[i]   = ($urandom_range(0, 1) == 1);
        d_v[i]    = 4'($urandom_range(0, 15));
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
